// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: reset vector, fetch FSM states
// and instruction width in bytes.
package mips_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
  localparam int unsigned INSTR_BYTES          = 4;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, drives the wait-request read bus and
// presents each fetched word to the control path under valid/ready.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_read_addr,
  output logic        instr_read,
  input  logic        instr_waitrequest,
  input  logic [31:0] instr_read_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_word,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        fetch_fault
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic [31:0]  addr_q;
  logic [31:0]  word_q;
  logic [31:0]  ipc_q;
  logic         discard_q;
  logic         pend_q;
  logic         fault_q;

  logic         misaligned;
  logic         done;
  logic [31:0]  pc_inc_d;

  assign misaligned = redirect && (redirect_target[1:0] != 2'b00);
  assign done       = !instr_waitrequest;
  assign pc_inc_d   = pc_q + 32'(INSTR_BYTES);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_VECTOR;
      addr_q    <= RESET_VECTOR;
      word_q    <= '0;
      ipc_q     <= '0;
      discard_q <= 1'b0;
      pend_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (misaligned) begin
            // A stalled read must still finish on the bus before going quiet.
            state_q   <= FAULT;
            fault_q   <= 1'b1;
            pend_q    <= instr_waitrequest;
            discard_q <= 1'b0;
          end else if (done) begin
            if (redirect) begin
              pc_q      <= redirect_target;
              addr_q    <= redirect_target;
              discard_q <= 1'b0;
            end else if (discard_q) begin
              addr_q    <= pc_q;
              discard_q <= 1'b0;
            end else begin
              word_q  <= instr_read_data;
              ipc_q   <= pc_q;
              pc_q    <= pc_inc_d;
              addr_q  <= pc_inc_d;
              state_q <= HOLD;
            end
          end else if (redirect) begin
            pc_q      <= redirect_target;
            discard_q <= 1'b1;
          end
        end
        HOLD: begin
          if (misaligned) begin
            state_q <= FAULT;
            fault_q <= 1'b1;
            pend_q  <= 1'b0;
          end else if (redirect) begin
            pc_q    <= redirect_target;
            addr_q  <= redirect_target;
            state_q <= FETCH;
          end else if (instr_ready) begin
            state_q <= FETCH;
          end
        end
        FAULT: begin
          if (pend_q && done) pend_q <= 1'b0;
        end
        default: state_q <= FAULT;
      endcase
    end
  end

  // Read request is state-decoded; reset masks it so it is low while reset is held.
  assign instr_read      = !reset && ((state_q == FETCH) || ((state_q == FAULT) && pend_q));
  assign instr_read_addr = addr_q;
  assign instr_valid     = (state_q == HOLD);
  assign instr_word      = word_q;
  assign instr_pc        = ipc_q;
  assign fetch_fault     = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, basic fetch, stalls, backpressure,
// redirects, PC wraparound and misaligned-redirect fault.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_read_addr;
  logic        instr_read;
  logic        instr_waitrequest;
  logic [31:0] instr_read_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_fault;

  int unsigned checks = 0;
  int unsigned errors = 0;

  fetch_unit #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk              (clk),
    .reset            (reset),
    .instr_read_addr  (instr_read_addr),
    .instr_read       (instr_read),
    .instr_waitrequest(instr_waitrequest),
    .instr_read_data  (instr_read_data),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_word       (instr_word),
    .instr_pc         (instr_pc),
    .redirect         (redirect),
    .redirect_target  (redirect_target),
    .fetch_fault      (fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory image: one fixed word at the reset vector, address-derived elsewhere.
  always_comb begin
    if (instr_read_addr == 32'hBFC00000) instr_read_data = 32'h20080005;
    else                                 instr_read_data = instr_read_addr ^ 32'hA5A50000;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; instr_waitrequest = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_target = '0;
    cyc(); cyc();
    checks++; if (instr_read !== 1'b0) begin errors++; $display("FAIL rst_read: got %b expected 0", instr_read); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
    checks++; if (instr_word !== 32'h0) begin errors++; $display("FAIL rst_word: got %h expected 0", instr_word); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 0", instr_pc); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", fetch_fault); end
    checks++; if (instr_read_addr !== 32'hBFC00000) begin errors++; $display("FAIL rst_addr: got %h expected bfc00000", instr_read_addr); end
    reset = 1'b0;
    #1;
    checks++; if (instr_read !== 1'b1) begin errors++; $display("FAIL first_read: got %b expected 1", instr_read); end
  endtask

  task automatic test_basic_fetch();
    cyc();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", instr_valid); end
    checks++; if (instr_pc !== 32'hBFC00000) begin errors++; $display("FAIL basic_pc: got %h expected bfc00000", instr_pc); end
    checks++; if (instr_word !== 32'h20080005) begin errors++; $display("FAIL basic_word: got %h expected 20080005", instr_word); end
    checks++; if (instr_read !== 1'b0) begin errors++; $display("FAIL basic_hold_read: got %b expected 0", instr_read); end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed: got %b expected 0", instr_valid); end
    checks++; if (instr_read !== 1'b1) begin errors++; $display("FAIL basic_refetch: got %b expected 1", instr_read); end
    checks++; if (instr_read_addr !== 32'hBFC00004) begin errors++; $display("FAIL basic_next_addr: got %h expected bfc00004", instr_read_addr); end
  endtask

  task automatic test_wait_stall();
    instr_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (instr_read_addr !== 32'hBFC00004) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected bfc00004", i, instr_read_addr); end
      checks++; if (instr_read !== 1'b1) begin errors++; $display("FAIL stall_read[%0d]: got %b expected 1", i, instr_read); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 0", i, instr_valid); end
    end
    instr_waitrequest = 1'b0;
    cyc();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_done_valid: got %b expected 1", instr_valid); end
    checks++; if (instr_pc !== 32'hBFC00004) begin errors++; $display("FAIL stall_done_pc: got %h expected bfc00004", instr_pc); end
    checks++; if (instr_word !== 32'h1A650004) begin errors++; $display("FAIL stall_done_word: got %h expected 1a650004", instr_word); end
  endtask

  task automatic test_hold_backpressure();
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b expected 1", i, instr_valid); end
      checks++; if (instr_word !== 32'h1A650004) begin errors++; $display("FAIL bp_word[%0d]: got %h expected 1a650004", i, instr_word); end
      checks++; if (instr_pc !== 32'hBFC00004) begin errors++; $display("FAIL bp_pc[%0d]: got %h expected bfc00004", i, instr_pc); end
      checks++; if (instr_read !== 1'b0) begin errors++; $display("FAIL bp_read[%0d]: got %b expected 0", i, instr_read); end
    end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    checks++; if (instr_read !== 1'b1) begin errors++; $display("FAIL bp_release_read: got %b expected 1", instr_read); end
    checks++; if (instr_read_addr !== 32'hBFC00008) begin errors++; $display("FAIL bp_release_addr: got %h expected bfc00008", instr_read_addr); end
  endtask

  task automatic test_redirect_stalled();
    instr_waitrequest = 1'b1;
    redirect = 1'b1; redirect_target = 32'h00500000;
    cyc();
    redirect_target = 32'h00400020;
    cyc();
    redirect = 1'b0;
    checks++; if (instr_read_addr !== 32'hBFC00008) begin errors++; $display("FAIL rds_addr_held: got %h expected bfc00008", instr_read_addr); end
    checks++; if (instr_read !== 1'b1) begin errors++; $display("FAIL rds_read_held: got %b expected 1", instr_read); end
    instr_waitrequest = 1'b0;
    cyc();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rds_dropped: got %b expected 0", instr_valid); end
    checks++; if (instr_read_addr !== 32'h00400020) begin errors++; $display("FAIL rds_target_addr: got %h expected 00400020", instr_read_addr); end
    checks++; if (instr_read !== 1'b1) begin errors++; $display("FAIL rds_target_read: got %b expected 1", instr_read); end
    cyc();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rds_valid: got %b expected 1", instr_valid); end
    checks++; if (instr_pc !== 32'h00400020) begin errors++; $display("FAIL rds_pc: got %h expected 00400020", instr_pc); end
    checks++; if (instr_word !== 32'hA5E50020) begin errors++; $display("FAIL rds_word: got %h expected a5e50020", instr_word); end
  endtask

  task automatic test_redirect_ready();
    instr_ready = 1'b1; redirect = 1'b1; redirect_target = 32'h00400100;
    cyc();
    instr_ready = 1'b0; redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rr_no_dup: got %b expected 0", instr_valid); end
    checks++; if (instr_read_addr !== 32'h00400100) begin errors++; $display("FAIL rr_addr: got %h expected 00400100", instr_read_addr); end
    cyc();
    checks++; if (instr_pc !== 32'h00400100) begin errors++; $display("FAIL rr_pc: got %h expected 00400100", instr_pc); end
    checks++; if (instr_word !== 32'hA5E50100) begin errors++; $display("FAIL rr_word: got %h expected a5e50100", instr_word); end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    checks++; if (instr_read_addr !== 32'h00400104) begin errors++; $display("FAIL rr_next_addr: got %h expected 00400104", instr_read_addr); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_target = 32'hFFFFFFFC;
    cyc();
    redirect = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL wrap_dropped: got %b expected 0", instr_valid); end
    checks++; if (instr_read_addr !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", instr_read_addr); end
    cyc();
    checks++; if (instr_pc !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_pc: got %h expected fffffffc", instr_pc); end
    checks++; if (instr_word !== 32'h5A5AFFFC) begin errors++; $display("FAIL wrap_word: got %h expected 5a5afffc", instr_word); end
    instr_ready = 1'b1;
    cyc();
    instr_ready = 1'b0;
    checks++; if (instr_read_addr !== 32'h00000000) begin errors++; $display("FAIL wrap_next: got %h expected 00000000", instr_read_addr); end
    checks++; if (instr_read !== 1'b1) begin errors++; $display("FAIL wrap_read: got %b expected 1", instr_read); end
  endtask

  task automatic test_fault();
    instr_waitrequest = 1'b1;
    cyc();
    redirect = 1'b1; redirect_target = 32'h00400022;
    cyc();
    redirect = 1'b0;
    checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL flt_flag: got %b expected 1", fetch_fault); end
    checks++; if (instr_read !== 1'b1) begin errors++; $display("FAIL flt_bus_busy: got %b expected 1", instr_read); end
    checks++; if (instr_read_addr !== 32'h00000000) begin errors++; $display("FAIL flt_addr: got %h expected 00000000", instr_read_addr); end
    instr_waitrequest = 1'b0;
    cyc();
    checks++; if (instr_read !== 1'b0) begin errors++; $display("FAIL flt_read_off: got %b expected 0", instr_read); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flt_valid: got %b expected 0", instr_valid); end
    redirect = 1'b1; redirect_target = 32'h00400020; instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL flt_sticky[%0d]: got %b expected 1", i, fetch_fault); end
      checks++; if (instr_read !== 1'b0) begin errors++; $display("FAIL flt_read_sticky[%0d]: got %b expected 0", i, instr_read); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL flt_valid_sticky[%0d]: got %b expected 0", i, instr_valid); end
    end
    redirect = 1'b0; instr_ready = 1'b0;
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL flt_cleared: got %b expected 0", fetch_fault); end
    checks++; if (instr_read !== 1'b1) begin errors++; $display("FAIL flt_restart_read: got %b expected 1", instr_read); end
    checks++; if (instr_read_addr !== 32'hBFC00000) begin errors++; $display("FAIL flt_restart_addr: got %h expected bfc00000", instr_read_addr); end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_wait_stall();
    test_hold_backpressure();
    test_redirect_stalled();
    test_redirect_ready();
    test_wrap();
    test_fault();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
